// File: rtl/mult_share_arbiter_if.sv
// Requester, response, multiplier and status signals of the shared-multiplier arbiter.
// The arbiter uses the slave modport; whatever drives requests and the multiplier uses master.
interface mult_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_prod;
    logic              rsp_ready;
    logic [3:0]        mul_x;
    logic [3:0]        mul_y;
    logic [7:0]        mul_z;
    logic [15:0]       done_cnt;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_z,
        output req_ready, rsp_valid, rsp_id, rsp_prod, mul_x, mul_y, done_cnt
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_z,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, mul_x, mul_y, done_cnt
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one external 4x4 multiplier: accept edge to rsp_valid is 2 edges.
// One transaction in flight; req_ready stays low until the response is taken by rsp_ready.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_id;
    logic [3:0]      r_op_a;
    logic [3:0]      r_op_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [7:0]      r_rsp_prod;
    logic [15:0]     r_done_cnt;

    logic            w_hi_vld;
    logic [IDW-1:0]  w_hi_idx;
    logic            w_lo_vld;
    logic [IDW-1:0]  w_lo_idx;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_idx;
    logic [3:0]      w_sel_a;
    logic [3:0]      w_sel_b;
    logic [NREQ-1:0] w_ready;
    logic            w_accept;

    // Requests above the last grant win first; otherwise wrap to the lowest valid index.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDW'(i);
            end
            if (bus.req_valid[i] && (IDW'(i) > r_last)) begin
                w_hi_vld = 1'b1;
                w_hi_idx = IDW'(i);
            end
        end
        w_gnt_vld = w_hi_vld | w_lo_vld;
        w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_a = bus.req_a[4*i +: 4];
                w_sel_b = bus.req_b[4*i +: 4];
            end
            w_ready[i] = (r_state == IDLE) && w_gnt_vld && (w_gnt_idx == IDW'(i));
        end
    end

    assign w_accept = (r_state == IDLE) && w_gnt_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC:    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers feed the multiplier directly and keep their value after CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a <= w_sel_a;
                        r_op_b <= w_sel_b;
                        r_id   <= w_gnt_idx;
                        r_last <= w_gnt_idx;
                    end
                end
                CALC: begin
                    r_rsp_prod  <= bus.mul_z;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_prod  = r_rsp_prod;
    assign bus.mul_x     = r_op_a;
    assign bus.mul_y     = r_op_b;
    assign bus.done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed stimulus for mult_share_arbiter with an external 4x4 multiplier model;
// responses are checked by a monitor against a scoreboard queue filled by the stimulus.
module tb_mult_share_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.NREQ(4), .IDW(2)) bus();

    assign bus.mul_z = {4'b0, bus.mul_x} * {4'b0, bus.mul_y};

    mult_share_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake must match the oldest expected {id, product}.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d prod=%0d, required no response",
                         bus.rsp_id, bus.rsp_prod);
            end else begin
                mon_exp = sb.pop_front();
                chk("rsp", {22'b0, bus.rsp_id, bus.rsp_prod}, {22'b0, mon_exp});
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[4*i +: 4] = a;
        bus.req_b[4*i +: 4] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    // Waits for a grant, checks it, and returns just after the accepting edge.
    task automatic do_accept(input int idx, input bit drop, output int gcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        gcyc = cyc;
        chk("grant", {28'b0, bus.req_ready}, 32'(1) << idx);
        @(posedge clk);
        #1;
        if (drop) bus.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_wait", {31'b0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {28'b0, bus.req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"},    {30'b0, bus.rsp_id},    32'd0);
        chk({tag, "_rsp_prod"},  {24'b0, bus.rsp_prod},  32'd0);
        chk({tag, "_mul_x"},     {28'b0, bus.mul_x},     32'd0);
        chk({tag, "_mul_y"},     {28'b0, bus.mul_y},     32'd0);
        chk({tag, "_done_cnt"},  {16'b0, bus.done_cnt},  32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int c[4];
        int g;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2: 13*11 = 143
        set_req(2, 4'd13, 4'd11);
        sb.push_back({2'd2, 8'd143});
        do_accept(2, 1'b1, g);
        @(negedge clk);
        chk("calc_mul_x", {28'b0, bus.mul_x}, 32'd13);
        chk("calc_mul_y", {28'b0, bus.mul_y}, 32'd11);
        chk("calc_req_ready", {28'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("t1_rsp_id", {30'b0, bus.rsp_id}, 32'd2);
        chk("t1_rsp_prod", {24'b0, bus.rsp_prod}, 32'd143);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("t1_done_cnt", {16'b0, bus.done_cnt}, 32'd1);
        chk("t1_rsp_cleared", {31'b0, bus.rsp_valid}, 32'd0);

        // All four valid after reset: grants 0,1,2,3, products 15,30,45,60, 3 cycles apart
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd15);
        sb.push_back({2'd0, 8'd15});
        sb.push_back({2'd1, 8'd30});
        sb.push_back({2'd2, 8'd45});
        sb.push_back({2'd3, 8'd60});
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_accept(k, 1'b1, c[k]);
            if (k > 0) chk("accept_gap", c[k] - c[k-1], 32'd3);
        end
        drain();
        chk("t2_done_cnt", {16'b0, bus.done_cnt}, 32'd4);

        // Backpressure on requester 1 (7*3 = 21) while requester 0 (5*5 = 25) waits
        bus.rsp_ready = 1'b0;
        set_req(1, 4'd7, 4'd3);
        sb.push_back({2'd1, 8'd21});
        do_accept(1, 1'b1, g);
        set_req(0, 4'd5, 4'd5);
        sb.push_back({2'd0, 8'd25});
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_id", {30'b0, bus.rsp_id}, 32'd1);
            chk("bp_rsp_prod", {24'b0, bus.rsp_prod}, 32'd21);
            chk("bp_req_ready", {28'b0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_cnt", {16'b0, bus.done_cnt}, 32'd5);
        do_accept(0, 1'b1, g);
        drain();
        chk("bp_done_cnt2", {16'b0, bus.done_cnt}, 32'd6);

        // Fairness: last grant was 0; requesters 0 (2*3) and 3 (4*4) held valid
        set_req(0, 4'd2, 4'd3);
        set_req(3, 4'd4, 4'd4);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                sb.push_back({2'd3, 8'd16});
                do_accept(3, 1'b0, g);
            end else begin
                sb.push_back({2'd0, 8'd6});
                do_accept(0, 1'b0, g);
            end
        end
        bus.req_valid = '0;
        drain();
        chk("fair_done_cnt", {16'b0, bus.done_cnt}, 32'd10);

        // Reset while requester 1 (9*9) is in CALC: no response, outputs cleared
        set_req(1, 4'd9, 4'd9);
        do_accept(1, 1'b1, g);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Corner products; requester 0 must win first after reset
        set_req(0, 4'd0, 4'd15);
        set_req(1, 4'd9, 4'd9);
        sb.push_back({2'd0, 8'd0});
        sb.push_back({2'd1, 8'd81});
        do_accept(0, 1'b1, g);
        do_accept(1, 1'b1, g);
        set_req(3, 4'd15, 4'd15);
        sb.push_back({2'd3, 8'd225});
        do_accept(3, 1'b1, g);
        drain();
        chk("final_done_cnt", {16'b0, bus.done_cnt}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
